// File: rtl/csr_hpm.sv
// Machine performance-counter bank: mcycle, minstret, NUM_HPM mhpmcounter/mhpmevent pairs, mcountinhibit.
// Define CSR_HPM_OVF_IRQ_EN to enable per-counter overflow flags (mhpmevent bit 31) and hpm_irq_o.
module csr_hpm #(
    parameter int NUM_HPM = 4,
    parameter int EVT_W   = 8,
    parameter int CNT_W   = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             csr_we_i,
    input  logic [11:0]      csr_addr_i,
    input  logic [31:0]      csr_wdata_i,
    output logic [31:0]      csr_rdata_o,
    input  logic             hx_valid,
    input  logic [EVT_W-1:0] evt_i,
    output logic             hpm_irq_o
);

    // Counter slots follow the CSR numbering: 0 mcycle, 1 unused (time), 2 minstret, 3+k hpm k.
    localparam int NCNT = NUM_HPM + 3;
    localparam logic [63:0] HPM_BITS = ((64'd1 << NUM_HPM) - 64'd1) << 3;
    localparam logic [31:0] INH_MASK = HPM_BITS[31:0] | 32'h0000_0005;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0]   cnt [NCNT];
    logic [7:0]         evt_sel [NUM_HPM];
    logic [NUM_HPM-1:0] of_q;
    logic [31:0]        inhibit_q;

    logic [4:0]      a_idx;
    logic            hit_lo, hit_hi, hit_grp3, inh_we;
    logic [NCNT-1:0] wr_lo, wr_hi, inc;
    logic [NUM_HPM-1:0] ev_we;

    assign a_idx    = csr_addr_i[4:0];
    assign hit_lo   = (csr_addr_i[11:5] == 7'b1011000);
    assign hit_hi   = (csr_addr_i[11:5] == 7'b1011100);
    assign hit_grp3 = (csr_addr_i[11:5] == 7'b0011001);
    assign inh_we   = csr_we_i & hit_grp3 & (a_idx == 5'd0);

    function automatic logic cnt_impl(input int i);
        return (i == 0) || (i >= 2 && i < NCNT);
    endfunction

    function automatic logic evt_hit(input logic [7:0] sel, input logic [EVT_W-1:0] evt);
        logic h;
        h = 1'b0;
        for (int j = 0; j < EVT_W; j++) begin
            if (sel == 8'(j + 1)) h = evt[j];
        end
        return h;
    endfunction

    always_comb begin
        wr_lo = '0;
        wr_hi = '0;
        inc   = '0;
        ev_we = '0;
        for (int i = 0; i < NCNT; i++) begin
            if (cnt_impl(i)) begin
                wr_lo[i] = csr_we_i & hit_lo & (a_idx == 5'(i));
                wr_hi[i] = csr_we_i & hit_hi & (a_idx == 5'(i));
            end
        end
        inc[0] = ~inhibit_q[0];
        inc[2] = ~inhibit_q[2] & hx_valid;
        for (int k = 0; k < NUM_HPM; k++) begin
            inc[k+3] = ~inhibit_q[k+3] & evt_hit(evt_sel[k], evt_i);
            ev_we[k] = csr_we_i & hit_grp3 & (a_idx == 5'(k + 3));
        end
    end

    // A write to either half takes priority over that counter's increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCNT; i++) cnt[i] <= '0;
            for (int k = 0; k < NUM_HPM; k++) evt_sel[k] <= '0;
            inhibit_q <= '0;
        end else begin
            if (inh_we) inhibit_q <= csr_wdata_i & INH_MASK;
            for (int i = 0; i < NCNT; i++) begin
                if (wr_lo[i])
                    cnt[i][31:0] <= csr_wdata_i;
                else if (wr_hi[i])
                    cnt[i][CNT_W-1:32] <= csr_wdata_i[CNT_W-33:0];
                else if (inc[i])
                    cnt[i] <= cnt[i] + CNT_ONE;
            end
            for (int k = 0; k < NUM_HPM; k++) begin
                if (ev_we[k]) evt_sel[k] <= csr_wdata_i[7:0];
            end
        end
    end

`ifdef CSR_HPM_OVF_IRQ_EN
    logic [NUM_HPM-1:0] wrap;
    logic               irq_q;

    always_comb begin
        wrap = '0;
        for (int k = 0; k < NUM_HPM; k++) begin
            wrap[k] = inc[k+3] & ~wr_lo[k+3] & ~wr_hi[k+3] & (&cnt[k+3]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            of_q  <= '0;
            irq_q <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_HPM; k++) begin
                if (ev_we[k])
                    of_q[k] <= csr_wdata_i[31];
                else if (wrap[k])
                    of_q[k] <= 1'b1;
            end
            irq_q <= |(of_q & ~inhibit_q[3 +: NUM_HPM]);
        end
    end

    assign hpm_irq_o = irq_q;
`else
    assign of_q      = '0;
    assign hpm_irq_o = 1'b0;
`endif

    always_comb begin
        logic [63:0] ext;
        ext         = '0;
        csr_rdata_o = '0;
        for (int i = 0; i < NCNT; i++) begin
            if (cnt_impl(i) && a_idx == 5'(i)) begin
                ext = 64'(cnt[i]);
                if (hit_lo) csr_rdata_o = ext[31:0];
                if (hit_hi) csr_rdata_o = ext[63:32];
            end
        end
        if (hit_grp3 && a_idx == 5'd0) csr_rdata_o = inhibit_q;
        for (int k = 0; k < NUM_HPM; k++) begin
            if (hit_grp3 && a_idx == 5'(k + 3))
                csr_rdata_o = {of_q[k], 23'd0, evt_sel[k]};
        end
    end

endmodule
